// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the four-digit multiplexed display scanner.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;

  localparam logic [NIB_W-1:0]      BLANK_CODE = 4'hF;
  localparam logic [NUM_DIGITS-1:0] ALL_OFF    = 4'b1111;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SLOT = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [NUM_DIGITS-1:0] digit_en;
    logic [NIB_W-1:0]      data;
    logic                  frame_start;
  } scan_out_t;

  localparam scan_out_t OUT_IDLE = '{digit_en: ALL_OFF, data: BLANK_CODE, frame_start: 1'b0};

  // Bit k set when digit k and every digit above it are zero; digit 0 never flagged.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [VALUE_W-1:0] v);
    logic upper_zero;
    lead_zero_mask = '0;
    upper_zero     = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
      upper_zero        = upper_zero & (v[k*NIB_W +: NIB_W] == '0);
      lead_zero_mask[k] = upper_zero;
    end
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Phase timer: counts elapsed cycles in the current GAP or SLOT phase and flags its last cycle.
module seg_scan_timer #(
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_in_slot,
  output logic o_slot_done_c,
  output logic o_gap_done_c
);

  localparam int unsigned MAX_LEN = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN);

  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign o_slot_done_c = i_in_slot  && (r_cnt == CNT_W'(CLK_DIV - 1));
  assign o_gap_done_c  = !i_in_slot && (r_cnt == CNT_W'(GAP_CYCLES - 1));
  assign w_done        = o_slot_done_c | o_gap_done_c;

  // Counter restarts at zero on every phase change, so each phase starts fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit time-multiplexed display scanner with anti-ghosting gaps between slots.
// Optional leading-zero blanking is compiled in with SEG_SCAN_LZB_EN.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  blank_lead,
  output logic [NIB_W-1:0]      data,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_start
);

  scan_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt, w_scan_idx;
  logic [VALUE_W-1:0] r_shadow, w_shadow_nxt;
  scan_out_t          r_out, w_out_nxt;
  logic [NIB_W-1:0]   w_nibble, w_slot_data;
  logic               w_slot_done, w_gap_done;

  seg_scan_timer #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_timer (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_in_slot     (r_state == ST_SLOT),
    .o_slot_done_c (w_slot_done),
    .o_gap_done_c  (w_gap_done)
  );

  // A load coinciding with slot entry must be visible in that slot.
  assign w_shadow_nxt = load ? value : r_shadow;
  assign w_scan_idx   = r_idx + IDX_W'(1);
  assign w_nibble     = w_shadow_nxt[w_scan_idx*NIB_W +: NIB_W];

`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] w_lz_mask;
  assign w_lz_mask   = lead_zero_mask(w_shadow_nxt);
  assign w_slot_data = (blank_lead && w_lz_mask[w_scan_idx]) ? BLANK_CODE : w_nibble;
`else
  logic w_unused_blank_lead;
  assign w_unused_blank_lead = blank_lead;
  assign w_slot_data         = w_nibble;
`endif

  always_comb begin
    w_state_nxt           = r_state;
    w_idx_nxt             = r_idx;
    w_out_nxt             = r_out;
    w_out_nxt.frame_start = 1'b0;
    case (r_state)
      ST_GAP: begin
        if (w_gap_done) begin
          w_state_nxt           = ST_SLOT;
          w_idx_nxt             = w_scan_idx;
          w_out_nxt.digit_en    = ~(NUM_DIGITS'(1) << w_scan_idx);
          w_out_nxt.data        = w_slot_data;
          w_out_nxt.frame_start = (w_scan_idx == '0);
        end
      end
      ST_SLOT: begin
        if (w_slot_done) begin
          w_state_nxt = ST_GAP;
          w_out_nxt   = OUT_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_GAP;
        w_out_nxt   = OUT_IDLE;
      end
    endcase
  end

  // idx resets to 3 so the first slot after reset is digit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_GAP;
      r_idx    <= IDX_W'(NUM_DIGITS - 1);
      r_shadow <= '0;
      r_out    <= OUT_IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      r_out    <= w_out_nxt;
    end
  end

  assign data        = r_out.data;
  assign digit_en    = r_out.digit_en;
  assign frame_start = r_out.frame_start;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with CLK_DIV=4, GAP_CYCLES=2; build with or without SEG_SCAN_LZB_EN.
module tb_seg_scan_mux;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 2;
`ifdef SEG_SCAN_LZB_EN
  localparam logic [3:0] Z = 4'hF;
`else
  localparam logic [3:0] Z = 4'h0;
`endif

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] d;
    logic       fs;
  } exp_t;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b1;
  logic        load       = 1'b0;
  logic        blank_lead = 1'b0;
  logic [15:0] value      = 16'h0000;
  logic [3:0]  data;
  logic [3:0]  digit_en;
  logic        frame_start;

  exp_t exp_q[$];
  exp_t ex;
  int   vectors = 0;
  int   errors  = 0;
  int   e       = 0;
  bit   in_slot = 1'b0;
  int   slot_len = 0;
  int   gap_len  = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .value       (value),
    .load        (load),
    .blank_lead  (blank_lead),
    .data        (data),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [3:0] en, input logic [3:0] d, input logic fs);
    exp_t x;
    x.en = en; x.d = d; x.fs = fs;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic goto_edge(input int t);
    while (e < t) step();
  endtask

  // Monitor: pops one expectation per slot entry and checks slot/gap shape.
  always @(negedge clk) begin
    if (!reset_n) begin
      in_slot  = 1'b0;
      gap_len  = 0;
      slot_len = 0;
    end else if (digit_en !== 4'hF) begin
      if (!in_slot) begin
        check("gap_len", 32'(gap_len), 32'(GAP_CYCLES));
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL slot_unexpected: got en=%b data=%h, required no slot", digit_en, data);
          ex = '{en: 4'hF, d: 4'hF, fs: 1'b0};
        end else begin
          ex = exp_q.pop_front();
          check("slot_en", 32'(digit_en), 32'(ex.en));
          check("slot_data", 32'(data), 32'(ex.d));
          check("slot_fs", 32'(frame_start), 32'(ex.fs));
        end
        in_slot  = 1'b1;
        slot_len = 1;
      end else begin
        slot_len++;
        check("hold_en", 32'(digit_en), 32'(ex.en));
        check("hold_data", 32'(data), 32'(ex.d));
        check("hold_fs", 32'(frame_start), 32'(0));
      end
    end else begin
      if (in_slot) begin
        check("slot_len", 32'(slot_len), 32'(CLK_DIV));
        in_slot = 1'b0;
        gap_len = 0;
      end
      gap_len++;
      check("gap_data", 32'(data), 32'hF);
      check("gap_fs", 32'(frame_start), 32'(0));
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, required $finish before 20000");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("rst_en", 32'(digit_en), 32'hF);
    check("rst_data", 32'(data), 32'hF);
    check("rst_fs", 32'(frame_start), 32'(0));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    e = 0;

    // Basic scan of 1234 and wrap back to digit 0.
    push(4'b1110, 4'h4, 1'b1);
    push(4'b1101, 4'h3, 1'b0);
    push(4'b1011, 4'h2, 1'b0);
    push(4'b0111, 4'h1, 1'b0);
    push(4'b1110, 4'h4, 1'b1);
    push(4'b1101, 4'h3, 1'b0);
    value = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;

    // Load during the digit-1 slot does not disturb it.
    goto_edge(33);
    push(4'b1011, 4'h9, 1'b0);
    push(4'b0111, 4'h9, 1'b0);
    push(4'b1110, 4'h9, 1'b1);
    value = 16'h9999; load = 1'b1;
    step();
    load = 1'b0;

    // Held load with changing value across the digit-1 slot entry at edge 56.
    goto_edge(54);
    push(4'b1101, 4'h7, 1'b0);
    push(4'b1011, 4'h8, 1'b0);
    push(4'b0111, 4'h0, 1'b0);
    push(4'b1110, 4'h0, 1'b1);
    value = 16'h1111; load = 1'b1;
    step();
    value = 16'h0070;
    step();
    value = 16'h0800;
    step();
    load = 1'b0;

    // Leading-zero cases with blank_lead requested.
    goto_edge(74);
    push(4'b1101, 4'h4, 1'b0);
    push(4'b1011, Z,    1'b0);
    push(4'b0111, Z,    1'b0);
    push(4'b1110, 4'h5, 1'b1);
    blank_lead = 1'b1; value = 16'h0045; load = 1'b1;
    step();
    load = 1'b0;

    goto_edge(98);
    push(4'b1101, Z,    1'b0);
    push(4'b1011, Z,    1'b0);
    push(4'b0111, Z,    1'b0);
    push(4'b1110, 4'h0, 1'b1);
    value = 16'h0000; load = 1'b1;
    step();
    load = 1'b0;

    goto_edge(122);
    push(4'b1101, 4'hA, 1'b0);
    push(4'b1011, Z,    1'b0);
    push(4'b0111, Z,    1'b0);
    push(4'b1110, 4'h0, 1'b1);
    push(4'b1101, 4'hA, 1'b0);
    push(4'b1011, Z,    1'b0);
    value = 16'h00A0; load = 1'b1;
    step();
    load = 1'b0;

    // Asynchronous reset in the middle of the digit-2 slot.
    goto_edge(159);
    #1 reset_n = 1'b0;
    #1;
    check("async_en", 32'(digit_en), 32'hF);
    check("async_data", 32'(data), 32'hF);
    check("async_fs", 32'(frame_start), 32'(0));
    repeat (3) step();
    reset_n = 1'b1;
    blank_lead = 1'b0;
    e = 0;

    push(4'b1110, 4'h0, 1'b1);
    push(4'b1101, 4'h7, 1'b0);
    push(4'b1011, 4'h6, 1'b0);
    push(4'b0111, 4'h5, 1'b0);
    push(4'b1110, 4'h8, 1'b1);
    goto_edge(2);
    value = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;

    goto_edge(31);
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
